// File: rtl/amo_seq.sv
// amo_seq: read-modify-write sequencer placed in front of the AMO compute unit.
// It takes one word AMO from execute and stalls the pipeline while it runs.
// It loads the word, passes the loaded value and rs2 to the AMO unit, and stores
// the unit's result back to memory. It then returns the original memory value
// for rd writeback. The block does no arithmetic; it only sequences and latches.

package amo_pkg;

    // AMO operation codes (funct5 encoding of the RV32A word AMOs).
    typedef enum logic [4:0] {
        AMOADD_W  = 5'b00000,
        AMOSWAP_W = 5'b00001,
        AMOXOR_W  = 5'b00100,
        AMOOR_W   = 5'b01000,
        AMOAND_W  = 5'b01100,
        AMOMIN_W  = 5'b10000,
        AMOMAX_W  = 5'b10100,
        AMOMINU_W = 5'b11000,
        AMOMAXU_W = 5'b11100
    } amoop_t;

endpackage

module amo_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      arst_n,

    // Request from execute
    input  logic                      amo_valid_in,
    input  amo_pkg::amoop_t           amoop_in,
    input  logic [DATA_WIDTH-1:0]     addr_in,
    input  logic [DATA_WIDTH-1:0]     rs2_in,

    // Pipeline / writeback
    output logic                      stall_out,
    output logic                      amo_done_out,
    output logic                      amo_err_out,
    output logic                      rd_we_out,
    output logic [DATA_WIDTH-1:0]     rd_data_out,

    // Data memory
    output logic                      mem_req_out,
    output logic                      mem_we_out,
    output logic [DATA_WIDTH-1:0]     mem_addr_out,
    output logic [DATA_WIDTH-1:0]     mem_wdata_out,
    output logic [DATA_WIDTH/8-1:0]   mem_mask_out,
    input  logic                      mem_gnt_in,
    input  logic                      mem_rvalid_in,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_in,
    input  logic                      mem_err_in,

    // AMO compute unit
    output logic                      amo_wr_en_out,
    output amo_pkg::amoop_t           amo_op_out,
    output logic [DATA_WIDTH-1:0]     amo_rs1_out,
    output logic [DATA_WIDTH-1:0]     amo_rs2_out,
    input  logic [DATA_WIDTH-1:0]     amo_result_in
);

    import amo_pkg::*;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_REQ  = 3'd1,
        LD_WAIT = 3'd2,
        EXEC    = 3'd3,
        RES     = 3'd4,
        ST_REQ  = 3'd5,
        ST_WAIT = 3'd6,
        DONE    = 3'd7
    } state_t;

    localparam logic [DATA_WIDTH-1:0]   ZERO_WORD = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH/8-1:0] FULL_MASK = {(DATA_WIDTH/8){1'b1}};

    // Registered state and the operands captured for the running AMO
    state_t                  state_r;
    logic [DATA_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   rs2_q;
    amoop_t                  op_q;
    logic [DATA_WIDTH-1:0]   old_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    err_q;

    // Next-state values
    state_t                  state_s;
    logic [DATA_WIDTH-1:0]   addr_s;
    logic [DATA_WIDTH-1:0]   rs2_s;
    amoop_t                  op_s;
    logic [DATA_WIDTH-1:0]   old_s;
    logic [DATA_WIDTH-1:0]   wdata_s;
    logic                    err_s;

    logic                    aligned_s;

    assign aligned_s = (addr_in[1:0] == 2'b00);

    // State and operand registers; reset abandons any AMO in flight.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r <= IDLE;
            addr_q  <= ZERO_WORD;
            rs2_q   <= ZERO_WORD;
            op_q    <= AMOADD_W;
            old_q   <= ZERO_WORD;
            wdata_q <= ZERO_WORD;
            err_q   <= 1'b0;
        end else begin
            state_r <= state_s;
            addr_q  <= addr_s;
            rs2_q   <= rs2_s;
            op_q    <= op_s;
            old_q   <= old_s;
            wdata_q <= wdata_s;
            err_q   <= err_s;
        end
    end

    // Next-state sequencing and operand capture for the load / compute / store walk.
    always_comb begin
        state_s = state_r;
        addr_s  = addr_q;
        rs2_s   = rs2_q;
        op_s    = op_q;
        old_s   = old_q;
        wdata_s = wdata_q;
        err_s   = err_q;

        case (state_r)
            IDLE: begin
                if (amo_valid_in) begin
                    if (aligned_s) begin
                        // Capture everything now; later changes on the inputs are ignored
                        addr_s  = addr_in;
                        rs2_s   = rs2_in;
                        op_s    = amoop_in;
                        state_s = LD_REQ;
                    end else begin
                        // Misaligned word AMO: report it without touching memory
                        err_s   = 1'b1;
                        state_s = DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end

            LD_REQ: begin
                // A stray rvalid here cannot belong to this load and is ignored
                if (mem_gnt_in) begin
                    state_s = LD_WAIT;
                end else begin
                    state_s = LD_REQ;
                end
            end

            LD_WAIT: begin
                if (mem_rvalid_in) begin
                    old_s = mem_rdata_in;
                    if (mem_err_in) begin
                        // Failed load: skip compute and store entirely
                        err_s   = 1'b1;
                        state_s = DONE;
                    end else begin
                        state_s = EXEC;
                    end
                end else begin
                    state_s = LD_WAIT;
                end
            end

            EXEC: begin
                state_s = RES;
            end

            RES: begin
                // The AMO unit registers its result, so it is valid one cycle after the strobe
                wdata_s = amo_result_in;
                state_s = ST_REQ;
            end

            ST_REQ: begin
                if (mem_gnt_in) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end

            ST_WAIT: begin
                if (mem_rvalid_in) begin
                    if (mem_err_in) begin
                        err_s = 1'b1;
                    end else begin
                        err_s = err_q;
                    end
                    state_s = DONE;
                end else begin
                    state_s = ST_WAIT;
                end
            end

            DONE: begin
                err_s   = 1'b0;
                state_s = IDLE;
            end

            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // The op is presented continuously; the unit only samples it on the compute strobe.
    assign amo_op_out = op_q;

    // Output decode from the registered state; every output not driven by a state is 0.
    always_comb begin
        stall_out     = 1'b0;
        amo_done_out  = 1'b0;
        amo_err_out   = 1'b0;
        rd_we_out     = 1'b0;
        rd_data_out   = ZERO_WORD;
        mem_req_out   = 1'b0;
        mem_we_out    = 1'b0;
        mem_addr_out  = ZERO_WORD;
        mem_wdata_out = ZERO_WORD;
        mem_mask_out  = {(DATA_WIDTH/8){1'b0}};
        amo_wr_en_out = 1'b0;
        amo_rs1_out   = ZERO_WORD;
        amo_rs2_out   = ZERO_WORD;

        case (state_r)
            IDLE: begin
                // Stall as soon as a request shows up; held low while reset is asserted
                stall_out = amo_valid_in & arst_n;
            end

            LD_REQ: begin
                stall_out    = 1'b1;
                mem_req_out  = 1'b1;
                mem_we_out   = 1'b0;
                mem_addr_out = addr_q;
                mem_mask_out = FULL_MASK;
            end

            LD_WAIT: begin
                stall_out = 1'b1;
            end

            EXEC: begin
                stall_out     = 1'b1;
                amo_wr_en_out = 1'b1;
                amo_rs1_out   = old_q;
                amo_rs2_out   = rs2_q;
            end

            RES: begin
                stall_out = 1'b1;
            end

            ST_REQ: begin
                stall_out     = 1'b1;
                mem_req_out   = 1'b1;
                mem_we_out    = 1'b1;
                mem_addr_out  = addr_q;
                mem_wdata_out = wdata_q;
                mem_mask_out  = FULL_MASK;
            end

            ST_WAIT: begin
                stall_out = 1'b1;
            end

            DONE: begin
                // Stall is released here so the pipeline advances with the writeback
                amo_done_out = 1'b1;
                amo_err_out  = err_q;
                rd_we_out    = ~err_q;
                rd_data_out  = old_q;
            end

            default: begin
                stall_out = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_amo_seq.sv
// tb_amo_seq: scoreboard bench for amo_seq with a behavioural data memory
// (programmable grant delay and load-error injection) and a registered AMO unit.

module tb_amo_seq;

    import amo_pkg::*;

    localparam int DW = 32;

    logic            clk;
    logic            arst_n;
    logic            amo_valid_in;
    amoop_t          amoop_in;
    logic [DW-1:0]   addr_in;
    logic [DW-1:0]   rs2_in;
    logic            stall_out;
    logic            amo_done_out;
    logic            amo_err_out;
    logic            rd_we_out;
    logic [DW-1:0]   rd_data_out;
    logic            mem_req_out;
    logic            mem_we_out;
    logic [DW-1:0]   mem_addr_out;
    logic [DW-1:0]   mem_wdata_out;
    logic [DW/8-1:0] mem_mask_out;
    logic            mem_gnt_in;
    logic            mem_rvalid_in;
    logic [DW-1:0]   mem_rdata_in;
    logic            mem_err_in;
    logic            amo_wr_en_out;
    amoop_t          amo_op_out;
    logic [DW-1:0]   amo_rs1_out;
    logic [DW-1:0]   amo_rs2_out;
    logic [DW-1:0]   amo_result_in;

    amo_seq #(.DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .amo_valid_in  (amo_valid_in),
        .amoop_in      (amoop_in),
        .addr_in       (addr_in),
        .rs2_in        (rs2_in),
        .stall_out     (stall_out),
        .amo_done_out  (amo_done_out),
        .amo_err_out   (amo_err_out),
        .rd_we_out     (rd_we_out),
        .rd_data_out   (rd_data_out),
        .mem_req_out   (mem_req_out),
        .mem_we_out    (mem_we_out),
        .mem_addr_out  (mem_addr_out),
        .mem_wdata_out (mem_wdata_out),
        .mem_mask_out  (mem_mask_out),
        .mem_gnt_in    (mem_gnt_in),
        .mem_rvalid_in (mem_rvalid_in),
        .mem_rdata_in  (mem_rdata_in),
        .mem_err_in    (mem_err_in),
        .amo_wr_en_out (amo_wr_en_out),
        .amo_op_out    (amo_op_out),
        .amo_rs1_out   (amo_rs1_out),
        .amo_rs2_out   (amo_rs2_out),
        .amo_result_in (amo_result_in)
    );

    typedef struct { logic [31:0] rs1; logic [31:0] rs2; } ex_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;
    typedef struct { logic err; logic [31:0] rd; int cyc; } dn_t;

    ex_t         ex_q[$];
    st_t         st_q[$];
    dn_t         dn_q[$];
    logic [31:0] ld_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_ld    = 0;
    int n_st    = 0;
    int n_wren  = 0;
    int n_done  = 0;
    int wait_cnt = 0;
    int ld_dly  = 0;
    int st_dly  = 0;
    logic ld_err_inj = 1'b0;
    logic [31:0] mem [0:255];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of the external AMO compute unit
    function automatic logic [31:0] amo_f(input amoop_t op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            AMOADD_W:  return a + b;
            AMOSWAP_W: return b;
            AMOXOR_W:  return a ^ b;
            AMOOR_W:   return a | b;
            AMOAND_W:  return a & b;
            AMOMIN_W:  return ($signed(a) < $signed(b)) ? a : b;
            AMOMAX_W:  return ($signed(a) > $signed(b)) ? a : b;
            AMOMINU_W: return (a < b) ? a : b;
            AMOMAXU_W: return (a > b) ? a : b;
            default:   return a;
        endcase
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Grant once the request has waited the programmed number of cycles
    always_comb mem_gnt_in = mem_req_out && (wait_cnt >= (mem_we_out ? st_dly : ld_dly));

    // Data memory: response one cycle after grant
    initial begin
        logic g, w, r;
        logic [31:0] a, d;
        mem_rvalid_in = 1'b0;
        mem_rdata_in  = 32'h0;
        mem_err_in    = 1'b0;
        forever begin
            @(posedge clk or negedge arst_n);
            if (!arst_n) begin
                mem_rvalid_in = 1'b0;
                mem_rdata_in  = 32'h0;
                mem_err_in    = 1'b0;
                wait_cnt      = 0;
            end else begin
                r = mem_req_out;
                g = mem_req_out && mem_gnt_in;
                w = mem_we_out;
                a = mem_addr_out;
                d = mem_wdata_out;
                if (g && w) begin
                    mem[a[9:2]] = d;
                    n_st++;
                end
                if (g && !w) n_ld++;
                #1;
                mem_rvalid_in = g;
                mem_rdata_in  = (g && !w) ? mem[a[9:2]] : 32'h0;
                mem_err_in    = g && !w && ld_err_inj;
                if (r && !g) wait_cnt++;
                else wait_cnt = 0;
            end
        end
    end

    // AMO unit: registered result one cycle after the strobe
    initial begin
        logic [31:0] res;
        amo_result_in = 32'h0;
        forever begin
            @(posedge clk);
            if (amo_wr_en_out) begin
                res = amo_f(amo_op_out, amo_rs1_out, amo_rs2_out);
                #1 amo_result_in = res;
            end
        end
    end

    // Monitor: pops scoreboard entries as the DUT produces them
    initial begin
        logic pw, pwe;
        logic [31:0] pa, pd;
        ex_t e;
        st_t s;
        dn_t dn;
        logic [31:0] la;
        pw = 1'b0; pwe = 1'b0; pa = 32'h0; pd = 32'h0;
        forever begin
            @(negedge clk);
            if (!arst_n) begin
                pw = 1'b0;
            end else begin
                if (pw && mem_req_out) begin
                    check_eq("req_addr_stable", mem_addr_out, pa);
                    check_eq("req_we_stable", 32'(mem_we_out), 32'(pwe));
                    check_eq("req_wdata_stable", mem_wdata_out, pd);
                end
                pw  = mem_req_out && !mem_gnt_in;
                pwe = mem_we_out;
                pa  = mem_addr_out;
                pd  = mem_wdata_out;

                if (mem_req_out && !mem_we_out && mem_gnt_in) begin
                    if (ld_q.size() == 0) check_eq("unexp_load", 32'h1, 32'h0);
                    else begin
                        la = ld_q.pop_front();
                        check_eq("load_addr", mem_addr_out, la);
                        check_eq("load_mask", 32'(mem_mask_out), 32'hF);
                    end
                end
                if (amo_wr_en_out) begin
                    n_wren++;
                    if (ex_q.size() == 0) check_eq("unexp_wren", 32'h1, 32'h0);
                    else begin
                        e = ex_q.pop_front();
                        check_eq("amo_rs1", amo_rs1_out, e.rs1);
                        check_eq("amo_rs2", amo_rs2_out, e.rs2);
                    end
                end
                if (mem_req_out && mem_we_out && mem_gnt_in) begin
                    if (st_q.size() == 0) check_eq("unexp_store", 32'h1, 32'h0);
                    else begin
                        s = st_q.pop_front();
                        check_eq("store_addr", mem_addr_out, s.addr);
                        check_eq("store_data", mem_wdata_out, s.data);
                        check_eq("store_mask", 32'(mem_mask_out), 32'hF);
                    end
                end
                if (amo_done_out) begin
                    n_done++;
                    if (dn_q.size() == 0) check_eq("unexp_done", 32'h1, 32'h0);
                    else begin
                        dn = dn_q.pop_front();
                        check_eq("done_err", 32'(amo_err_out), 32'(dn.err));
                        check_eq("done_rd_we", 32'(rd_we_out), 32'(!dn.err));
                        if (!dn.err) check_eq("done_rd_data", rd_data_out, dn.rd);
                        check_eq("done_cycle", 32'(cyc), 32'(dn.cyc));
                    end
                end
            end
        end
    end

    // Drive one request and push what the DUT must produce for it
    task automatic start_amo(input amoop_t op, input logic [31:0] a, input logic [31:0] b,
                             input int ldd, input int std, input logic lerr, input int extra);
        logic [31:0] old;
        logic mis;
        int lat;
        ex_t e;
        st_t s;
        dn_t dn;
        old = mem[a[9:2]];
        mis = (a[1:0] != 2'b00);
        ld_dly = ldd;
        st_dly = std;
        ld_err_inj = lerr;
        amo_valid_in = 1'b1;
        amoop_in = op;
        addr_in = a;
        rs2_in = b;
        if (mis) lat = 1;
        else if (lerr) lat = 3 + ldd;
        else lat = 7 + ldd + std;
        if (!mis) ld_q.push_back(a);
        if (!mis && !lerr) begin
            e.rs1 = old; e.rs2 = b; ex_q.push_back(e);
            s.addr = a; s.data = amo_f(op, old, b); st_q.push_back(s);
        end
        dn.err = mis || lerr;
        dn.rd  = old;
        dn.cyc = cyc + extra + lat;
        dn_q.push_back(dn);
    endtask

    // Wait for the completion pulse, checking stall on every cycle on the way
    task automatic wait_done(input string tag);
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            #1;
            if (amo_done_out) begin
                check_eq({tag, "_stall_done"}, 32'(stall_out), 32'h0);
                break;
            end
            check_eq({tag, "_stall_busy"}, 32'(stall_out), 32'h1);
            k++;
            if (k > 40) begin
                check_eq({tag, "_timeout"}, 32'h0, 32'h1);
                break;
            end
        end
    endtask

    initial begin
        int l0, s0, w0, d0, k;
        arst_n = 1'b0;
        amo_valid_in = 1'b0;
        amoop_in = AMOADD_W;
        addr_in = 32'h0;
        rs2_in = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        // Reset state
        #1;
        check_eq("rst_stall", 32'(stall_out), 32'h0);
        check_eq("rst_done", 32'(amo_done_out), 32'h0);
        check_eq("rst_err", 32'(amo_err_out), 32'h0);
        check_eq("rst_rd_we", 32'(rd_we_out), 32'h0);
        check_eq("rst_rd_data", rd_data_out, 32'h0);
        check_eq("rst_mem_req", 32'(mem_req_out), 32'h0);
        check_eq("rst_mem_we", 32'(mem_we_out), 32'h0);
        check_eq("rst_mem_addr", mem_addr_out, 32'h0);
        check_eq("rst_mem_wdata", mem_wdata_out, 32'h0);
        check_eq("rst_mem_mask", 32'(mem_mask_out), 32'h0);
        check_eq("rst_wr_en", 32'(amo_wr_en_out), 32'h0);
        check_eq("rst_op", 32'(amo_op_out), 32'h0);
        check_eq("rst_rs1", amo_rs1_out, 32'h0);
        check_eq("rst_rs2", amo_rs2_out, 32'h0);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        #1 check_eq("idle_stall", 32'(stall_out), 32'h0);

        // 1: AMOADD, zero-wait memory
        mem[32'h100 >> 2] = 32'd5;
        l0 = n_ld; s0 = n_st;
        @(negedge clk);
        start_amo(AMOADD_W, 32'h100, 32'd3, 0, 0, 1'b0, 0);
        #1 check_eq("t1_stall_accept", 32'(stall_out), 32'h1);
        wait_done("t1");
        amo_valid_in = 1'b0;
        check_eq("t1_mem", mem[32'h100 >> 2], 32'd8);
        check_eq("t1_loads", 32'(n_ld - l0), 32'd1);
        check_eq("t1_stores", 32'(n_st - s0), 32'd1);

        // 2: backpressure on load and store, inputs change after acceptance
        mem[32'h200 >> 2] = 32'h0000_1234;
        l0 = n_ld; s0 = n_st;
        @(negedge clk);
        start_amo(AMOXOR_W, 32'h200, 32'h0000_FF00, 3, 2, 1'b0, 0);
        @(posedge clk);
        #1;
        addr_in = 32'h0000_0300;
        rs2_in = 32'hDEAD_BEEF;
        amoop_in = AMOSWAP_W;
        wait_done("t2");
        amo_valid_in = 1'b0;
        check_eq("t2_mem", mem[32'h200 >> 2], 32'h0000_ED34);
        check_eq("t2_loads", 32'(n_ld - l0), 32'd1);
        check_eq("t2_stores", 32'(n_st - s0), 32'd1);

        // 3: misaligned address
        l0 = n_ld; s0 = n_st; w0 = n_wren;
        @(negedge clk);
        start_amo(AMOADD_W, 32'h102, 32'd1, 0, 0, 1'b0, 0);
        wait_done("t3");
        amo_valid_in = 1'b0;
        check_eq("t3_loads", 32'(n_ld - l0), 32'd0);
        check_eq("t3_stores", 32'(n_st - s0), 32'd0);
        check_eq("t3_wren", 32'(n_wren - w0), 32'd0);

        // 4: load error
        mem[32'h104 >> 2] = 32'h0000_00F0;
        l0 = n_ld; s0 = n_st; w0 = n_wren;
        @(negedge clk);
        start_amo(AMOOR_W, 32'h104, 32'h0000_000F, 1, 0, 1'b1, 0);
        wait_done("t4");
        amo_valid_in = 1'b0;
        ld_err_inj = 1'b0;
        check_eq("t4_loads", 32'(n_ld - l0), 32'd1);
        check_eq("t4_stores", 32'(n_st - s0), 32'd0);
        check_eq("t4_wren", 32'(n_wren - w0), 32'd0);
        check_eq("t4_mem", mem[32'h104 >> 2], 32'h0000_00F0);

        // 5: reset while the store is waiting for grant
        mem[32'h0C0 >> 2] = 32'd7;
        s0 = n_st;
        @(negedge clk);
        start_amo(AMOAND_W, 32'h0C0, 32'd3, 0, 5, 1'b0, 0);
        k = 0;
        while (!(mem_req_out && mem_we_out) && k < 30) begin
            @(negedge clk);
            k++;
        end
        check_eq("t5_reached_store", 32'(mem_req_out && mem_we_out), 32'h1);
        #2;
        amo_valid_in = 1'b0;
        arst_n = 1'b0;
        #1;
        check_eq("t5_req_drop", 32'(mem_req_out), 32'h0);
        check_eq("t5_we", 32'(mem_we_out), 32'h0);
        check_eq("t5_addr", mem_addr_out, 32'h0);
        check_eq("t5_wdata", mem_wdata_out, 32'h0);
        check_eq("t5_stall", 32'(stall_out), 32'h0);
        check_eq("t5_done", 32'(amo_done_out), 32'h0);
        check_eq("t5_rd_we", 32'(rd_we_out), 32'h0);
        check_eq("t5_rd_data", rd_data_out, 32'h0);
        ex_q.delete(); st_q.delete(); dn_q.delete(); ld_q.delete();
        d0 = n_done;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("t5_no_done", 32'(n_done - d0), 32'd0);
        check_eq("t5_no_store", 32'(n_st - s0), 32'd0);
        check_eq("t5_mem_kept", mem[32'h0C0 >> 2], 32'd7);
        mem[32'h040 >> 2] = 32'h0000_00AA;
        @(negedge clk);
        start_amo(AMOSWAP_W, 32'h040, 32'h0000_0055, 0, 0, 1'b0, 0);
        wait_done("t5b");
        amo_valid_in = 1'b0;
        check_eq("t5b_mem", mem[32'h040 >> 2], 32'h0000_0055);

        // 6: back-to-back with valid held across DONE
        mem[32'h080 >> 2] = 32'h0000_0010;
        @(negedge clk);
        start_amo(AMOMAXU_W, 32'h080, 32'h0000_0020, 0, 0, 1'b0, 0);
        wait_done("t6a");
        start_amo(AMOADD_W, 32'h080, 32'h0000_0001, 0, 0, 1'b0, 1);
        wait_done("t6b");
        amo_valid_in = 1'b0;
        check_eq("t6_mem", mem[32'h080 >> 2], 32'h0000_0021);

        // 7: signed minimum with single-cycle waits on both accesses
        mem[32'h084 >> 2] = 32'hFFFF_FFF0;
        @(negedge clk);
        start_amo(AMOMIN_W, 32'h084, 32'h0000_0005, 1, 1, 1'b0, 0);
        wait_done("t7");
        amo_valid_in = 1'b0;
        check_eq("t7_mem", mem[32'h084 >> 2], 32'hFFFF_FFF0);

        repeat (3) @(negedge clk);
        check_eq("end_dn_q", 32'(dn_q.size()), 32'd0);
        check_eq("end_st_q", 32'(st_q.size()), 32'd0);
        check_eq("end_ex_q", 32'(ex_q.size()), 32'd0);
        check_eq("end_ld_q", 32'(ld_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
